// File: rtl/stage3_mem_arbiter.sv
// Shares one memory bus between fetch (I) and data (D) ports; grant registered, bus strobe one cycle after request.
// D has priority but a saturating streak counter forces an I grant; requesters stall on busy until completion.
module stage3_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ren,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_busy,
  input  logic                d_ren,
  input  logic                d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byte_en,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_busy,
  output logic                m_ren,
  output logic                m_wen,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_byte_en,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_busy
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] d_streak, streak_nxt;
  logic          d_req;

  assign d_req   = d_ren | d_wen;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      d_streak <= '0;
    end else begin
      state    <= state_nxt;
      d_streak <= streak_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    streak_nxt = d_streak;
    m_ren      = 1'b0;
    m_wen      = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_byte_en  = '0;
    i_busy     = 1'b1;
    d_busy     = 1'b1;
    case (state)
      IDLE: begin
        // D wins unless I is waiting and D has already used its full streak
        if (d_req && !(i_ren && d_streak == STREAK_MAX)) begin
          state_nxt = SERVE_D;
          if (d_streak != STREAK_MAX) streak_nxt = d_streak + 1'b1;
        end else if (i_ren) begin
          state_nxt  = SERVE_I;
          streak_nxt = '0;
        end
      end
      SERVE_I: begin
        // strobe held even if i_ren drops: bus accesses are never aborted
        m_ren     = 1'b1;
        m_addr    = i_addr;
        m_byte_en = '1;
        i_busy    = m_busy;
        if (!m_busy) state_nxt = IDLE;
      end
      SERVE_D: begin
        m_ren     = d_ren;
        m_wen     = d_wen;
        m_addr    = d_addr;
        m_wdata   = d_wdata;
        m_byte_en = d_byte_en;
        d_busy    = m_busy;
        if (!m_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stage3_mem_arbiter.sv
// Bench for stage3_mem_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level owner/streak model.
module tb_stage3_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_ren, d_ren, d_wen, m_busy;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, m_rdata, i_rdata, d_rdata, m_wdata;
  logic [3:0]    d_byte_en, m_byte_en;
  logic          i_busy, d_busy, m_ren, m_wen;

  int checks = 0;
  int failures = 0;

  // model: who owns the bus (0 none, 1 I, 2 D) and D grants since the last I grant
  int own = 0;
  int d_since_i = 0;
  int eff;
  logic i_seen_done = 1'b0;
  logic d_seen_done = 1'b0;

  stage3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_busy(d_busy),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_byte_en(m_byte_en), .m_rdata(m_rdata), .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  always @(posedge clk)
    if (!rst) assert (!(d_ren && d_wen)) else $error("FAIL d_rw_exclusive both strobes requested");

  // per-cycle model compare, then advance the model with the inputs seen at the coming edge
  always @(negedge clk) begin
    i_seen_done = !i_busy;
    d_seen_done = !d_busy;
    if (own == 0) begin
      chk("m_m_ren_idle", m_ren, 0);
      chk("m_m_wen_idle", m_wen, 0);
      chk("m_addr_idle", m_addr, 0);
      chk("m_wdata_idle", m_wdata, 0);
      chk("m_be_idle", m_byte_en, 0);
      chk("m_i_busy_idle", i_busy, 1);
      chk("m_d_busy_idle", d_busy, 1);
    end else if (own == 1) begin
      chk("m_m_ren_i", m_ren, 1);
      chk("m_m_wen_i", m_wen, 0);
      chk("m_addr_i", m_addr, i_addr);
      chk("m_be_i", m_byte_en, 4'hf);
      chk("m_i_busy_i", i_busy, m_busy);
      chk("m_d_busy_i", d_busy, 1);
      if (!m_busy) chk("m_i_rdata", i_rdata, m_rdata);
    end else begin
      chk("m_m_ren_d", m_ren, d_ren);
      chk("m_m_wen_d", m_wen, d_wen);
      chk("m_addr_d", m_addr, d_addr);
      chk("m_wdata_d", m_wdata, d_wdata);
      chk("m_be_d", m_byte_en, d_byte_en);
      chk("m_d_busy_d", d_busy, m_busy);
      chk("m_i_busy_d", i_busy, 1);
      if (!m_busy) chk("m_d_rdata", d_rdata, m_rdata);
    end
    eff = (d_since_i > MAX) ? MAX : d_since_i;
    if (rst) begin
      own = 0;
      d_since_i = 0;
    end else if (own != 0) begin
      if (!m_busy) own = 0;
    end else if ((d_ren || d_wen) && !(i_ren && eff == MAX)) begin
      own = 2;
      d_since_i++;
    end else if (i_ren) begin
      own = 1;
      d_since_i = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] seq;
    int ng;
    logic drop_i;
    rst = 1'b1; i_ren = 0; i_addr = 0; d_ren = 0; d_wen = 0; d_addr = 0;
    d_wdata = 0; d_byte_en = 0; m_busy = 0; m_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    obs();
    chk("rst_m_ren", m_ren, 0);
    chk("rst_m_wen", m_wen, 0);
    chk("rst_i_busy", i_busy, 1);
    chk("rst_d_busy", d_busy, 1);

    // I read with two wait states
    nxt(); i_ren = 1; i_addr = 32'h100; m_busy = 1;
    obs(); chk("i_idle_m_ren", m_ren, 0);
    nxt(); obs();
    chk("i_c1_m_ren", m_ren, 1); chk("i_c1_busy", i_busy, 1);
    chk("i_c1_addr", m_addr, 32'h100); chk("i_c1_be", m_byte_en, 4'hf);
    nxt(); obs();
    chk("i_c2_m_ren", m_ren, 1); chk("i_c2_busy", i_busy, 1);
    nxt(); m_busy = 0; m_rdata = 32'hdeadbeef; obs();
    chk("i_c3_m_ren", m_ren, 1); chk("i_c3_busy", i_busy, 0);
    chk("i_c3_rdata", i_rdata, 32'hdeadbeef);
    nxt(); i_ren = 0; obs();
    chk("i_after_m_ren", m_ren, 0);

    // simultaneous I read and D store: D first, I after one idle cycle
    nxt(); i_ren = 1; i_addr = 32'h104; d_wen = 1; d_addr = 32'h40;
    d_wdata = 32'hcafef00d; d_byte_en = 4'h3; m_busy = 0;
    obs();
    nxt(); obs();
    chk("both_d_wen", m_wen, 1); chk("both_d_ren", m_ren, 0);
    chk("both_d_addr", m_addr, 32'h40); chk("both_d_wdata", m_wdata, 32'hcafef00d);
    chk("both_d_be", m_byte_en, 4'h3); chk("both_d_busy", d_busy, 0);
    chk("both_d_ibusy", i_busy, 1);
    nxt(); d_wen = 0; obs();
    chk("both_gap_ren", m_ren, 0); chk("both_gap_wen", m_wen, 0);
    nxt(); obs();
    chk("both_i_ren", m_ren, 1); chk("both_i_addr", m_addr, 32'h104);
    chk("both_i_busy", i_busy, 0);
    nxt(); i_ren = 0; obs();

    // streak limit: continuous D with I pending
    nxt(); i_ren = 1; i_addr = 32'h108; d_ren = 1; d_addr = 32'h80; d_byte_en = 4'hf;
    seq = 0; ng = 0;
    for (int k = 0; k < 30 && ng < 6; k++) begin
      drop_i = 1'b0;
      obs();
      if (!i_busy) begin
        seq = {seq[4:0], 1'b0}; ng++; drop_i = 1'b1;
      end else if (!d_busy) begin
        seq = {seq[4:0], 1'b1}; ng++;
      end
      nxt();
      if (drop_i) i_ren = 0;
    end
    d_ren = 0; i_ren = 0;
    chk("streak_grants", ng, 6);
    chk("streak_order", seq, 6'b111101);
    obs();

    // I flushed mid access: strobe held, D waits
    nxt(); i_ren = 1; i_addr = 32'h300; m_busy = 1;
    obs();
    nxt(); obs(); chk("flush_c1_ren", m_ren, 1);
    nxt(); i_ren = 0; d_ren = 1; d_addr = 32'h200; obs();
    chk("flush_c2_ren", m_ren, 1); chk("flush_c2_addr", m_addr, 32'h300);
    chk("flush_c2_dbusy", d_busy, 1);
    nxt(); obs(); chk("flush_c3_ren", m_ren, 1); chk("flush_c3_dbusy", d_busy, 1);
    nxt(); m_busy = 0; obs();
    chk("flush_c4_ren", m_ren, 1); chk("flush_c4_ibusy", i_busy, 0);
    chk("flush_c4_dbusy", d_busy, 1);
    nxt(); obs(); chk("flush_gap_ren", m_ren, 0); chk("flush_gap_dbusy", d_busy, 1);
    nxt(); obs();
    chk("flush_d_ren", m_ren, 1); chk("flush_d_addr", m_addr, 32'h200);
    chk("flush_d_busy", d_busy, 0);
    nxt(); d_ren = 0; obs();

    // reset during a D store
    nxt(); d_wen = 1; d_addr = 32'h44; d_wdata = 32'h12345678; d_byte_en = 4'hf; m_busy = 1;
    obs();
    nxt(); obs(); chk("rstd_wen", m_wen, 1); chk("rstd_busy", d_busy, 1);
    nxt(); rst = 1; obs(); chk("rstd_pre_wen", m_wen, 1);
    nxt(); rst = 0; d_wen = 0; obs();
    chk("rstd_post_wen", m_wen, 0); chk("rstd_post_ren", m_ren, 0);
    chk("rstd_post_dbusy", d_busy, 1); chk("rstd_streak", dut.d_streak, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      nxt();
      rst = ($urandom_range(0, 299) == 0);
      if (i_ren && i_seen_done) begin
        i_ren = 1'($urandom_range(0, 1));
        i_addr = $urandom;
      end else if (i_ren && $urandom_range(0, 39) == 0) begin
        i_ren = 0;
      end else if (!i_ren && $urandom_range(0, 2) == 0) begin
        i_ren = 1;
        i_addr = $urandom;
      end
      if (!(d_ren || d_wen) || d_seen_done) begin
        if ($urandom_range(0, 1) == 1) begin
          d_wen = 1'($urandom_range(0, 1));
          d_ren = !d_wen;
          d_addr = $urandom;
          d_wdata = $urandom;
          d_byte_en = 4'($urandom_range(0, 15));
        end else begin
          d_ren = 0;
          d_wen = 0;
        end
      end
      m_busy = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
    end
    nxt();
    obs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
